cp0_unit: RTL and testbench



---
 rtl/cp0_unit.sv | 114 +++++++++++
 tb/tb_cp0_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: Coprocessor-0 exception/interrupt controller (SR, Cause, EPC).
// Samples HWInt every cycle, arbitrates interrupts against pipeline
// exception codes, and serves mfc0/mtc0/eret at the M stage.
// Optional feature macro: CP0_BD_EN -- when defined, Cause.BD records the
// BD input and EPC is rewound by 4 for delay-slot victims.
module cp0_unit #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RAddr,
  input  logic [4:0]  WAddr,
  input  logic        WE,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BD,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut
);

  localparam logic [4:0] R_SR    = 5'd12;
  localparam logic [4:0] R_CAUSE = 5'd13;
  localparam logic [4:0] R_EPC   = 5'd14;

  // The handler address is consumed by the CPU, not by this block.
  logic [31:0] unused_entry;
  assign unused_entry = EXC_ENTRY;

  // Architectural state, only the implemented fields are stored.
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        cause_bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        int_req;
  logic        exc_req;
  logic [4:0]  code_next;
  logic        bd_next;
  logic [31:0] epc_next;

  assign sr_word    = {16'b0, im, 8'b0, exl, ie};
  assign cause_word = {cause_bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
  assign Req     = int_req | exc_req;

  // Interrupts win over a simultaneous pipeline exception and record code 0.
  assign code_next = int_req ? 5'd0 : ExcCodeIn;

`ifdef CP0_BD_EN
  assign bd_next  = BD;
  assign epc_next = BD ? (VPC - 32'd4) : VPC;
`else
  logic unused_bd;
  assign unused_bd = BD;
  assign bd_next   = 1'b0;
  assign epc_next  = VPC;
`endif

  assign EPCOut = epc;

  // mfc0 read mux; unimplemented register numbers read as zero.
  always_comb begin
    CP0Out = 32'd0;
    case (RAddr)
      R_SR:    CP0Out = sr_word;
      R_CAUSE: CP0Out = cause_word;
      R_EPC:   CP0Out = epc;
      default: CP0Out = 32'd0;
    endcase
  end

  // Register update: reset, then exception entry, else eret / mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      cause_bd <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        // Exception entry swallows any same-cycle mtc0 or eret.
        exl      <= 1'b1;
        exc_code <= code_next;
        cause_bd <= bd_next;
        epc      <= epc_next;
      end else begin
        if (WE && WAddr == R_SR) begin
          im  <= CP0In[15:10];
          ie  <= CP0In[0];
          exl <= CP0In[1];
        end
        // eret dominates an SR write's EXL bit.
        if (EXLClr) exl <= 1'b0;
        if (WE && WAddr == R_EPC) epc <= CP0In;
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: scoreboard bench for cp0_unit. A word-level reference model
// produces the expected Req/CP0Out/EPCOut for every issued cycle; a monitor
// on the falling edge pops and compares against the DUT.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RAddr, WAddr, ExcCodeIn;
  logic        WE, BD, EXLClr;
  logic [31:0] CP0In, VPC;
  logic [5:0]  HWInt;
  logic [31:0] CP0Out, EPCOut;
  logic        Req;

  cp0_unit dut (
    .clk(clk), .reset(reset), .RAddr(RAddr), .WAddr(WAddr), .WE(WE),
    .CP0In(CP0In), .CP0Out(CP0Out), .VPC(VPC), .BD(BD),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .Req(Req), .EPCOut(EPCOut)
  );

  always #5 clk = ~clk;

`ifdef CP0_BD_EN
  localparam bit BD_EN = 1'b1;
`else
  localparam bit BD_EN = 1'b0;
`endif

  typedef struct {
    bit        req;
    bit [31:0] rd;
    bit [31:0] epc;
    int        idx;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Reference model: whole register words.
  bit [31:0] m_sr, m_cause, m_epc;
  bit        m_valid = 1'b0;

  task automatic cyc(input logic r, input logic [4:0] ra, input logic [4:0] wa,
                     input logic we, input logic [31:0] din, input logic [31:0] vpc_i,
                     input logic bd_i, input logic [4:0] exc, input logic [5:0] hw,
                     input logic clr);
    bit        ireq, ereq, req;
    bit [31:0] rd;
    bit [4:0]  code;
    exp_t      e;
    reset = r; RAddr = ra; WAddr = wa; WE = we; CP0In = din; VPC = vpc_i;
    BD = bd_i; ExcCodeIn = exc; HWInt = hw; EXLClr = clr;

    ireq = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    ereq = (exc != 5'd0) && !m_sr[1];
    req  = ireq || ereq;
    if (ra == 5'd12)      rd = m_sr;
    else if (ra == 5'd13) rd = m_cause;
    else if (ra == 5'd14) rd = m_epc;
    else                  rd = 32'd0;

    if (m_valid) begin
      e.req = req; e.rd = rd; e.epc = m_epc; e.idx = cyc_no;
      q.push_back(e);
    end

    if (r) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_valid = 1'b1;
    end else if (req) begin
      code    = ireq ? 5'd0 : exc;
      m_sr    = m_sr | 32'h2;
      m_cause = ((BD_EN && bd_i) ? 32'h8000_0000 : 32'd0)
              | (32'(hw) << 10) | (32'(code) << 2);
      m_epc   = (BD_EN && bd_i) ? vpc_i - 32'd4 : vpc_i;
    end else begin
      if (we && wa == 5'd12) m_sr = din & 32'h0000_FC03;
      if (clr) m_sr = m_sr & ~32'h2;
      if (we && wa == 5'd14) m_epc = din;
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
    end

    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare combinational outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks += 3;
      if (Req !== e.req) begin
        n_fail++;
        $display("FAIL req cyc %0d: got %b want %b", e.idx, Req, e.req);
      end
      if (CP0Out !== e.rd) begin
        n_fail++;
        $display("FAIL cp0out cyc %0d raddr %0d: got %h want %h", e.idx, RAddr, CP0Out, e.rd);
      end
      if (EPCOut !== e.epc) begin
        n_fail++;
        $display("FAIL epcout cyc %0d: got %h want %h", e.idx, EPCOut, e.epc);
      end
    end
  end

  initial begin
    reset = 1'b1; RAddr = 0; WAddr = 0; WE = 0; CP0In = 0; VPC = 0; BD = 0;
    ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    @(posedge clk); #1;

    // Reset: everything reads 0, no request even with all lines high.
    cyc(1, 12, 0, 0, 0, 0, 0, 0, 6'h3F, 0);
    cyc(1, 12, 0, 0, 0, 0, 0, 0, 6'h3F, 0);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 6'h3F, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 6'h3F, 0);
    cyc(0, 12, 0, 0, 0, 0, 0, 0, 6'h3F, 0);

    // Enable IM[2]+IE, then raise line 2 -> same-cycle request.
    cyc(0, 12, 12, 1, 32'h0000_0401, 0, 0, 0, 6'h00, 0);
    cyc(0, 12, 0, 0, 0, 32'h3010, 0, 0, 6'b000001, 0);
    cyc(0, 12, 0, 0, 0, 0, 0, 0, 6'b000001, 0);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 6'b000001, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 6'b000001, 0);

    // EXL masks an exception; eret re-enables it on the next cycle.
    cyc(0, 13, 0, 0, 0, 32'h3014, 0, 5'd10, 6'h00, 0);
    cyc(0, 13, 0, 0, 0, 32'h3014, 0, 5'd10, 6'h00, 1);
    cyc(0, 13, 0, 0, 0, 32'h3014, 0, 5'd10, 6'h00, 0);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0);

    // Interrupt beats exception; same-cycle mtc0 EPC is discarded.
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 1);
    cyc(0, 14, 14, 1, 32'hDEAD, 32'h3040, 0, 5'd4, 6'b000001, 0);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0);

    // Delay-slot victim.
    cyc(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 1);
    cyc(0, 12, 0, 0, 0, 32'h3020, 1, 5'd12, 6'h00, 0);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0);

    // Cause is read-only; unimplemented register reads 0.
    cyc(0, 13, 13, 1, 32'hFFFF_FFFF, 0, 0, 0, 6'h00, 0);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0);
    cyc(0, 5, 0, 0, 0, 0, 0, 0, 6'h00, 0);
    // mtc0 EPC outside exception, readback has no bypass.
    cyc(0, 14, 14, 1, 32'h1234_5678, 0, 0, 0, 6'h00, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ra, wa, exc;
      case ($urandom_range(0, 3))
        0: ra = 12; 1: ra = 13; 2: ra = 14; default: ra = 5'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: wa = 12; 1: wa = 13; 2: wa = 14; default: wa = 5'($urandom);
      endcase
      exc = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      cyc($urandom_range(0, 199) == 0, ra, wa, $urandom_range(0, 2) == 0,
          $urandom, {$urandom, 2'b00} & 32'hFFFF_FFFC, 1'($urandom), exc,
          6'($urandom), $urandom_range(0, 7) == 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
